// File: rtl/mc_cpu_core.sv
// mc_cpu_core -- multi-cycle 8-bit-ISA CPU core.
//
// Executes the 8-bit ISA (ADD / LW / SW / BR) through a FETCH, DECODE,
// EXEC, MEM, WB state sequence. A single ALU adder serves ADD and the
// LW/SW address computation. The 4-entry register file and the data memory
// live inside the core. Instruction memory is external and combinational.
//
// Parameters:
//   DATA_W     register / ALU / data-memory word width (>= 4)
//   PC_W       program counter and imem_addr width
//   DMEM_DEPTH data-memory words (power of 2), addressed by low ALU bits
//
// Ports:
//   clock      system clock, rising edge
//   reset      asynchronous active-high reset, clears all state
//   run        sampled only in FETCH; low holds the core in FETCH
//   imem_addr  instruction address (= PC)
//   imem_data  instruction byte at imem_addr, sampled in FETCH
//   pc_out     current PC
//   wb_data    last value written to the register file
//   wb_valid   one-cycle pulse per register-file write
//   retire     one-cycle pulse per completed instruction
//   state_out  FSM state: FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 HALT=5
//
// Build option:
//   HALT_DETECT_EN  when defined, a branch to itself (BR with imm = -1)
//                   parks the core in HALT until reset.

module mc_cpu_core #(
    parameter int DATA_W     = 8,
    parameter int PC_W       = 8,
    parameter int DMEM_DEPTH = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              run,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [7:0]        imem_data,
    output logic [PC_W-1:0]   pc_out,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_valid,
    output logic              retire,
    output logic [2:0]        state_out
);

    localparam int AW = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_LW  = 2'b01;
    localparam logic [1:0] OP_SW  = 2'b10;
    localparam logic [1:0] OP_BR  = 2'b11;

`ifdef HALT_DETECT_EN
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;
`endif

    state_t              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [7:0]          ir_q, ir_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [DATA_W-1:0]   alu_q, alu_d;
    logic [DATA_W-1:0]   mdr_q, mdr_d;
    logic [DATA_W-1:0]   wb_data_q, wb_data_d;
    logic                wb_valid_q, wb_valid_d;
    logic                retire_q, retire_d;

    logic [DATA_W-1:0]   rf_q   [4];
    logic [DATA_W-1:0]   rf_d   [4];
    logic [DATA_W-1:0]   dmem_q [DMEM_DEPTH];
    logic [DATA_W-1:0]   dmem_d [DMEM_DEPTH];
    logic [DATA_W-1:0]   dmem_init [DMEM_DEPTH];

    // Instruction fields
    logic [1:0]          op, rs, rt, rd;
    logic [DATA_W-1:0]   imm_dw;
    logic [PC_W-1:0]     imm_pc;
    logic [DATA_W-1:0]   alu_sum;
    logic [AW-1:0]       dmem_addr;
    logic [PC_W-1:0]     pc_inc;
    logic [PC_W-1:0]     pc_branch;
    logic [1:0]          wb_reg;
    logic [DATA_W-1:0]   wb_value;

    // Reset image of the data memory: word i holds i (truncated).
    for (genvar gi = 0; gi < DMEM_DEPTH; gi++) begin : g_dmem_init
        assign dmem_init[gi] = DATA_W'(gi);
    end

    assign op = ir_q[7:6];
    assign rs = ir_q[5:4];
    assign rt = ir_q[3:2];
    assign rd = ir_q[1:0];

    // 2-bit immediate, sign-extended to both datapath widths
    assign imm_dw = {{(DATA_W-2){ir_q[1]}}, ir_q[1:0]};
    assign imm_pc = {{(PC_W-2){ir_q[1]}}, ir_q[1:0]};

    // The one shared adder: ADD uses B, loads/stores use the immediate.
    assign alu_sum   = a_q + ((op == OP_ADD) ? b_q : imm_dw);
    // Only the low address bits select a word; upper ALU bits are ignored.
    assign dmem_addr = AW'(alu_q);
    assign pc_inc    = pc_q + PC_W'(1);
    assign pc_branch = pc_inc + imm_pc;

    // ADD writes rd from the ALU; LW writes rt from the memory data register.
    assign wb_reg   = (op == OP_ADD) ? rd : rt;
    assign wb_value = (op == OP_ADD) ? alu_q : mdr_q;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        a_d        = a_q;
        b_d        = b_q;
        alu_d      = alu_q;
        mdr_d      = mdr_q;
        wb_data_d  = wb_data_q;
        wb_valid_d = 1'b0;
        retire_d   = 1'b0;
        rf_d       = rf_q;
        dmem_d     = dmem_q;

        case (state_q)
            S_FETCH: begin
                if (run) begin
                    ir_d    = imem_data;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d     = rf_q[rs];
                b_d     = rf_q[rt];
                state_d = S_EXEC;
            end
            S_EXEC: begin
                case (op)
                    OP_BR: begin
                        retire_d = 1'b1;
`ifdef HALT_DETECT_EN
                        if (ir_q[1:0] == 2'b11) begin
                            // Branch to itself: park instead of spinning.
                            state_d = S_HALT;
                        end else begin
                            pc_d    = pc_branch;
                            state_d = S_FETCH;
                        end
`else
                        pc_d    = pc_branch;
                        state_d = S_FETCH;
`endif
                    end
                    OP_ADD: begin
                        alu_d   = alu_sum;
                        state_d = S_WB;
                    end
                    default: begin
                        alu_d   = alu_sum;
                        state_d = S_MEM;
                    end
                endcase
            end
            S_MEM: begin
                if (op == OP_LW) begin
                    mdr_d   = dmem_q[dmem_addr];
                    state_d = S_WB;
                end else begin
                    dmem_d[dmem_addr] = b_q;
                    pc_d              = pc_inc;
                    retire_d          = 1'b1;
                    state_d           = S_FETCH;
                end
            end
            S_WB: begin
                rf_d[wb_reg] = wb_value;
                wb_data_d    = wb_value;
                wb_valid_d   = 1'b1;
                pc_d         = pc_inc;
                retire_d     = 1'b1;
                state_d      = S_FETCH;
            end
`ifdef HALT_DETECT_EN
            S_HALT: begin
                state_d = S_HALT;
            end
`endif
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_FETCH;
            pc_q       <= '0;
            ir_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            alu_q      <= '0;
            mdr_q      <= '0;
            wb_data_q  <= '0;
            wb_valid_q <= 1'b0;
            retire_q   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                rf_q[i] <= '0;
            end
            for (int i = 0; i < DMEM_DEPTH; i++) begin
                dmem_q[i] <= dmem_init[i];
            end
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            a_q        <= a_d;
            b_q        <= b_d;
            alu_q      <= alu_d;
            mdr_q      <= mdr_d;
            wb_data_q  <= wb_data_d;
            wb_valid_q <= wb_valid_d;
            retire_q   <= retire_d;
            rf_q       <= rf_d;
            dmem_q     <= dmem_d;
        end
    end

    assign imem_addr = pc_q;
    assign pc_out    = pc_q;
    assign wb_data   = wb_data_q;
    assign wb_valid  = wb_valid_q;
    assign retire    = retire_q;
    assign state_out = state_q;

endmodule

// File: tb/tb_mc_cpu_core.sv
// tb_mc_cpu_core -- self-checking bench for mc_cpu_core.
//
// An instruction-level ISA model (register file, data memory, PC as plain
// integers) predicts every retirement: PC after the instruction, whether a
// register write happens and its value, and the cycle count per instruction.
// Between retirements the expected state code follows the per-opcode state
// sequence. Directed programs cover the listed scenarios; a random program
// with random run stalls covers the rest.

module tb_mc_cpu_core;

    localparam int DW = 8;
    localparam int PW = 8;
    localparam int DD = 16;

`ifdef HALT_DETECT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          run   = 1'b0;
    logic [PW-1:0] imem_addr;
    logic [7:0]    imem_data;
    logic [PW-1:0] pc_out;
    logic [DW-1:0] wb_data;
    logic          wb_valid;
    logic          retire;
    logic [2:0]    state_out;

    logic [7:0]    imem [256];

    int total = 0;
    int bad   = 0;

    // Reference model state
    int m_rf   [4];
    int m_dmem [DD];
    int m_pc;
    int m_cnt;
    bit m_halted;

    mc_cpu_core #(.DATA_W(DW), .PC_W(PW), .DMEM_DEPTH(DD)) dut (
        .clock     (clock),
        .reset     (reset),
        .run       (run),
        .imem_addr (imem_addr),
        .imem_data (imem_data),
        .pc_out    (pc_out),
        .wb_data   (wb_data),
        .wb_valid  (wb_valid),
        .retire    (retire),
        .state_out (state_out)
    );

    always #5 clock = ~clock;

    assign imem_data = imem[imem_addr];

    task automatic check_eq(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int cpi_of(input logic [1:0] op);
        case (op)
            2'b00:   return 4;
            2'b01:   return 5;
            2'b10:   return 4;
            default: return 3;
        endcase
    endfunction

    // State code after k completed edges of an instruction.
    function automatic int state_after(input logic [1:0] op, input int k);
        if (k <= 2) return k;
        if (k == 3) return (op == 2'b00) ? 4 : 3;
        return 4;
    endfunction

    function automatic int wrap(input int x, input int m);
        return ((x % m) + m) % m;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_rf[i] = 0;
        for (int i = 0; i < DD; i++) m_dmem[i] = i % (1 << DW);
        m_pc     = 0;
        m_cnt    = 0;
        m_halted = 1'b0;
    endtask

    // Assert reset between edges, check the asynchronous clear, release.
    task automatic do_reset(input bit check_now);
        @(negedge clock);
        #2 reset = 1'b1;
        run = 1'b0;
        #1;
        if (check_now) begin
            check_eq("rst_pc",       pc_out,    0);
            check_eq("rst_state",    state_out, 0);
            check_eq("rst_wb_valid", wb_valid,  0);
            check_eq("rst_retire",   retire,    0);
            check_eq("rst_wb_data",  wb_data,   0);
        end
        repeat (2) @(negedge clock);
        reset = 1'b0;
        model_reset();
    endtask

    // One sampled cycle: advance the model and compare.
    task automatic step_and_check();
        logic [7:0] ir;
        logic [1:0] op;
        int rs, rt, rd, imm, addr, v, cpi;
        bit exp_wb;
        bit halting;
        ir  = imem[m_pc];
        op  = ir[7:6];
        cpi = cpi_of(op);
        if (m_halted) begin
            check_eq("halt_state",  state_out, 5);
            check_eq("halt_retire", retire,    0);
            check_eq("halt_pc",     pc_out,    m_pc);
            return;
        end
        // A FETCH cycle with run low makes no progress.
        if (!(m_cnt == 0 && !run)) m_cnt++;
        if (m_cnt == cpi) begin
            rs = int'(ir[5:4]);
            rt = int'(ir[3:2]);
            rd = int'(ir[1:0]);
            imm = (ir[1:0] >= 2'd2) ? int'(ir[1:0]) - 4 : int'(ir[1:0]);
            exp_wb  = 1'b0;
            halting = 1'b0;
            v = 0;
            case (op)
                2'b00: begin
                    v = wrap(m_rf[rs] + m_rf[rt], 1 << DW);
                    m_rf[rd] = v;
                    exp_wb = 1'b1;
                    m_pc = wrap(m_pc + 1, 1 << PW);
                end
                2'b01: begin
                    addr = wrap(m_rf[rs] + imm, DD);
                    v = m_dmem[addr];
                    m_rf[rt] = v;
                    exp_wb = 1'b1;
                    m_pc = wrap(m_pc + 1, 1 << PW);
                end
                2'b10: begin
                    addr = wrap(m_rf[rs] + imm, DD);
                    m_dmem[addr] = m_rf[rt];
                    m_pc = wrap(m_pc + 1, 1 << PW);
                end
                default: begin
                    if (HALT_EN && imm == -1) halting = 1'b1;
                    else m_pc = wrap(m_pc + 1 + imm, 1 << PW);
                end
            endcase
            check_eq("retire",    retire,   1);
            check_eq("wb_valid",  wb_valid, int'(exp_wb));
            if (exp_wb) check_eq("wb_data", wb_data, v);
            check_eq("pc",        pc_out,    m_pc);
            check_eq("imem_addr", imem_addr, m_pc);
            check_eq("state_ret", state_out, halting ? 5 : 0);
            $display("txn ir=%02h op=%0d wb=%0d data=%0d next_pc=%0d state=%0d",
                     ir, op, wb_valid, wb_data, pc_out, state_out);
            m_cnt = 0;
            m_halted = halting;
        end else begin
            check_eq("no_retire", retire,    0);
            check_eq("no_wb",     wb_valid,  0);
            check_eq("pc_hold",   pc_out,    m_pc);
            check_eq("state_seq", state_out, state_after(op, m_cnt));
        end
    endtask

    // mode 0: run high, 1: random run, 2: run low
    task automatic run_cycles(input int n, input int mode);
        for (int k = 0; k < n; k++) begin
            case (mode)
                0:       run = 1'b1;
                1:       run = ($urandom_range(0, 4) != 0);
                default: run = 1'b0;
            endcase
            @(negedge clock);
            step_and_check();
        end
    endtask

    initial begin
        logic [7:0] b;
        model_reset();

        // Program 1: load/add/store/load sequence, then branches.
        for (int i = 0; i < 256; i++) imem[i] = 8'h00;
        imem[0] = 8'h45;   // LW  r1, 1(r0)   -> r1 = 1
        imem[1] = 8'h16;   // ADD r2 = r1+r1  -> 2
        imem[2] = 8'hA5;   // SW  r1 -> 1(r2) -> dmem[3] = 1
        imem[3] = 8'h6D;   // LW  r3, 1(r2)   -> 1
        imem[4] = 8'h00;   // ADD r0 = r0+r0
        imem[5] = 8'hC1;   // BR +1 -> 7
        imem[6] = 8'h1B;   // ADD r3 = r1+r2
        imem[7] = 8'hC2;   // BR -2 -> 6
        do_reset(1'b0);
        // run low for 10 cycles: core must hold in FETCH at PC 0
        run_cycles(10, 2);
        run_cycles(60, 0);

        // Asynchronous reset mid-program.
        do_reset(1'b1);

        // Program 2: random code with stalls; PC 0 branches back to 0xFF.
        for (int i = 0; i < 256; i++) begin
            b = 8'($urandom_range(0, 255));
            if (b[7:6] == 2'b11 && b[1:0] == 2'b11) b[1:0] = 2'b01;
            imem[i] = b;
        end
        imem[0]   = 8'hC2; // BR -2 at PC 0 -> PC 0xFF
        imem[255] = 8'hC1; // BR +1 at 0xFF -> PC 1
        run_cycles(700, 1);

        // Program 3: self-branch at PC 4.
        do_reset(1'b1);
        for (int i = 0; i < 256; i++) imem[i] = 8'h00;
        imem[1] = 8'h45;
        imem[4] = 8'hC3;
        run_cycles(45, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
